// File: rtl/time_set_ctrl.sv
// Set-time controller for the sec/min/hour counters: debounces the MODE and
// INC buttons, walks RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> RUN, edits a
// captured copy of the time and commits it with a one-cycle load strobe.
module time_set_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic       clk_in_50M,
  input  logic       rst,
  input  logic       key_mode_n,
  input  logic       key_inc_n,
  input  logic       blink_in,
  input  logic [6:0] cur_sec,
  input  logic [6:0] cur_min,
  input  logic [6:0] cur_hour,
  output logic       en_sec,
  output logic       en_min,
  output logic       en_hour,
  output logic       load_sec,
  output logic       load_min,
  output logic       load_hour,
  output logic [6:0] data_sec,
  output logic [6:0] data_min,
  output logic [6:0] data_hour,
  output logic [1:0] mode,
  output logic       blink_sec,
  output logic       blink_min,
  output logic       blink_hour
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StSetHour = 2'd1,
    StSetMin  = 2'd2,
    StSetSec  = 2'd3
  } state_e;

  // Bit 0 is the MODE key, bit 1 the INC key.
  logic [1:0]       keys;
  logic [1:0]       sync1_q;
  logic [1:0]       sync2_q;
  logic [1:0]       deb_q;
  logic [1:0]       deb_prev_q;
  logic [CNT_W-1:0] cnt_q [2];
  logic [1:0]       press;
  logic             mode_press;
  logic             inc_press;

  state_e     state_q;
  logic [6:0] hour_q;
  logic [6:0] min_q;
  logic [6:0] sec_q;
  logic       en_q;
  logic       load_q;

  assign keys       = {key_inc_n, key_mode_n};
  // Press is the 1->0 edge of the debounced level; releases are ignored.
  assign press      = deb_prev_q & ~deb_q;
  assign mode_press = press[0];
  assign inc_press  = press[1];

  // Synchronize both keys and accept a level only after it has been stable.
  always_ff @(posedge clk_in_50M or posedge rst) begin
    if (rst) begin
      sync1_q    <= 2'b11;
      sync2_q    <= 2'b11;
      deb_q      <= 2'b11;
      deb_prev_q <= 2'b11;
      for (int i = 0; i < 2; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q    <= keys;
      sync2_q    <= sync1_q;
      deb_prev_q <= deb_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CntMax) begin
          deb_q[i] <= sync2_q[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Set-time FSM with edit registers and registered enable/load outputs.
  always_ff @(posedge clk_in_50M or posedge rst) begin
    if (rst) begin
      state_q <= StRun;
      hour_q  <= '0;
      min_q   <= '0;
      sec_q   <= '0;
      en_q    <= 1'b1;
      load_q  <= 1'b0;
    end else begin
      load_q <= 1'b0;
      case (state_q)
        StRun: begin
          en_q <= 1'b1;
          if (mode_press) begin
            state_q <= StSetHour;
            en_q    <= 1'b0;
            // Sanitize the live time so editing always starts in range.
            hour_q  <= (cur_hour > 7'd23) ? 7'd0 : cur_hour;
            min_q   <= (cur_min > 7'd59) ? 7'd0 : cur_min;
            sec_q   <= (cur_sec > 7'd59) ? 7'd0 : cur_sec;
          end
        end
        StSetHour: begin
          en_q <= 1'b0;
          if (mode_press) begin
            state_q <= StSetMin;
          end else if (inc_press) begin
            hour_q <= (hour_q >= 7'd23) ? 7'd0 : hour_q + 7'd1;
          end
        end
        StSetMin: begin
          en_q <= 1'b0;
          if (mode_press) begin
            state_q <= StSetSec;
          end else if (inc_press) begin
            min_q <= (min_q >= 7'd59) ? 7'd0 : min_q + 7'd1;
          end
        end
        StSetSec: begin
          en_q <= 1'b0;
          if (mode_press) begin
            // Commit: counters stay held during the load cycle, resume after.
            state_q <= StRun;
            load_q  <= 1'b1;
          end else if (inc_press) begin
            sec_q <= (sec_q >= 7'd59) ? 7'd0 : sec_q + 7'd1;
          end
        end
        default: begin
          state_q <= StRun;
          en_q    <= 1'b1;
        end
      endcase
    end
  end

  assign mode      = state_q;
  assign en_sec    = en_q;
  assign en_min    = en_q;
  assign en_hour   = en_q;
  assign load_sec  = load_q;
  assign load_min  = load_q;
  assign load_hour = load_q;
  assign data_sec  = sec_q;
  assign data_min  = min_q;
  assign data_hour = hour_q;

  // Blank only the field currently being edited, in step with blink_in.
  always_comb begin
    blink_hour = (state_q == StSetHour) & blink_in;
    blink_min  = (state_q == StSetMin) & blink_in;
    blink_sec  = (state_q == StSetSec) & blink_in;
  end

endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
- Upstream control stage for the clock's sec/min/hour counters.
- Debounces two raw push-buttons (MODE, INC) and runs a set-time state machine.
- In RUN it holds all counters enabled. In the set states it freezes the counters and edits a captured copy of the time.
- On exiting SET_SEC it drives the counters' load strobes and preset data to commit the edited time.
- It also emits per-field blink masks for the seven-segment stage.

Parameters:
DEBOUNCE_CYCLES, 1000000, clock cycles a synchronized key level must be stable before it is accepted (20 ms at 50 MHz)
CNT_W, 20, width of debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES

Ports:
clk_in_50M  input  1  system clock, 50 MHz, all logic on rising edge
rst  input  1  asynchronous, active-high reset
key_mode_n  input  1  raw MODE button, active-low, asynchronous to clock
key_inc_n  input  1  raw INC button, active-low, asynchronous to clock
blink_in  input  1  ~1 Hz square wave used for field blinking
cur_sec  input  7  live seconds count, binary 0-59
cur_min  input  7  live minutes count, binary 0-59
cur_hour  input  7  live hours count, binary 0-23
en_sec, en_min, en_hour  output  1 each  counter enables; 1 = count, 0 = hold
load_sec, load_min, load_hour  output  1 each  one-cycle load strobes
data_sec, data_min, data_hour  output  7 each  preset data to counters; binary
mode  output  2  0 RUN, 1 SET_HOUR, 2 SET_MIN, 3 SET_SEC
blink_sec, blink_min, blink_hour  output  1 each  1 = blank this field's display

Behaviour:
- Reset (async, active-high), all values forced while rst = 1:
  - mode = RUN.
  - en_* = 1, load_* = 0.
  - Edit registers, and therefore data_*, = 0.
  - Synchronizers = 1 (released key); debounced levels = 1; debounce counters = 0.
- Reset asserted mid-edit abandons the edit: no load is issued, and mode returns to RUN.
- Key input path, per key:
  - 2-FF synchronizer.
  - Debounce counter clears whenever the synchronized level equals the debounced level. Otherwise it increments.
  - When the counter reaches DEBOUNCE_CYCLES-1, the debounced level takes the synchronized level and the counter clears.
  - A 1->0 transition of the debounced level produces a one-cycle press pulse. Release produces no event.
  - Glitches shorter than DEBOUNCE_CYCLES produce no pulse.
- FSM transitions on mode press: RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> RUN.
- RUN -> SET_HOUR:
  - Edit registers capture cur_hour/cur_min/cur_sec in the same cycle the state changes.
  - Any captured value out of range (hour > 23, min/sec > 59) is replaced by 0.
  - en_* go 0 from the next cycle on.
- Set states:
  - en_* = 0.
  - An INC press increments only the field being edited. Hour wraps 23 -> 0; min/sec wrap 59 -> 0.
  - Other fields are unchanged.
- SET_SEC -> RUN (commit):
  - In the cycle after the transition, load_sec, load_min and load_hour = 1 for exactly one cycle, with en_* still 0.
  - data_* hold the edited values during the load cycle.
  - en_* return to 1 in the following cycle.
- data_* always equal the edit registers. They keep their values in RUN until the next capture.
- Simultaneous MODE and INC pulses in one cycle: MODE wins and INC is discarded.
- INC in RUN is ignored.
- mode output is the registered state.
- Blink masks:
  - blink_hour = (mode == SET_HOUR) & blink_in; same pattern for min (SET_MIN) and sec (SET_SEC).
  - Combinational from registered mode.
  - All blink masks are 0 in RUN.
- Latency: a raw key stable low from cycle t yields the press pulse within DEBOUNCE_CYCLES+3 cycles. The state/edit update is visible the cycle after the pulse.

Test Plan:
- Reset and idle (DEBOUNCE_CYCLES = 4):
  - Stimulus: assert rst mid-run, then release, with no key activity.
  - Required: mode = 0, en_* = 1, load_* = 0 and data_* = 0 while rst is high, and they stay so after release.
- Debounce:
  - Stimulus: key_mode_n low for 2 cycles, then high.
  - Required: mode stays 0.
  - Stimulus: key_mode_n low for 20 cycles.
  - Required: mode becomes 1 within DEBOUNCE_CYCLES+4 cycles of the falling edge, and exactly one transition occurs.
- Capture and wrap:
  - Stimulus: cur_hour = 23, cur_min = 59, cur_sec = 58. Press MODE, then press INC once.
  - Required: data_hour goes 23 -> 0.
  - Stimulus: press MODE, then INC twice.
  - Required: data_min = 0 -> 1.
- Full commit:
  - Stimulus: from captured 10:20:30, give hour +2, min +0, sec +5, then MODE.
  - Required: a single cycle with load_* = 1, en_* = 0, data_hour = 12, data_min = 20, data_sec = 35; en_* = 1 on the next cycle.
- Simultaneous, out-of-range capture and reset:
  - Stimulus: MODE and INC pulses in the same cycle while in SET_MIN.
  - Required: mode becomes 3 and data_min is unchanged.
  - Stimulus: cur_min = 99 at capture.
  - Required: data_min = 0.
  - Stimulus: rst in SET_MIN.
  - Required: no load pulse ever seen, and mode = 0.
- Blink:
  - Stimulus: drive blink_in as a toggling square wave while in SET_MIN.
  - Required: blink_min follows blink_in, and blink_hour = blink_sec = 0; in RUN all blink outputs are 0.
